// File: rtl/demux_rr_dispatch.sv
// Round-robin dispatcher feeding a 4-way demux: holds one item, grants one
// enabled and ready consumer, and presents the item with a one-hot valid.
module demux_rr_dispatch #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         in_ready,
   input  logic [3:0]   mask,
   input  logic [3:0]   out_ready,
   output logic [1:0]   sel,
   output logic [3:0]   out_valid,
   output logic [W-1:0] out_data,
   output logic         busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ARB  = 2'd1,
      S_SEND = 2'd2
   } state_t;

   state_t       r_state;
   state_t       w_state_nxt;
   logic [1:0]   r_ptr;
   logic [1:0]   r_sel;
   logic [W-1:0] r_data;

   logic [3:0]   w_cand;
   logic [1:0]   w_scan;
   logic [1:0]   w_gnt;
   logic         w_found;
   logic         w_load;
   logic         w_grant;
   logic         w_done;

   assign w_cand = mask & out_ready;

   // First candidate at or after the pointer, wrapping modulo 4.
   always_comb begin
      w_found = 1'b0;
      w_gnt   = r_ptr;
      w_scan  = r_ptr;
      for (int k = 0; k < 4; k++) begin
         w_scan = r_ptr + 2'(k);
         if (!w_found && w_cand[w_scan]) begin
            w_found = 1'b1;
            w_gnt   = w_scan;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_grant     = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (in_valid) begin
               w_load      = 1'b1;
               w_state_nxt = S_ARB;
            end
         end
         S_ARB: begin
            if (w_found) begin
               w_grant     = 1'b1;
               w_state_nxt = S_SEND;
            end
         end
         S_SEND: begin
            if (out_ready[r_sel]) begin
               w_done      = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr  <= 2'b00;
         r_sel  <= 2'b00;
         r_data <= '0;
      end else begin
         if (w_load) begin
            r_data <= in_data;
         end
         if (w_grant) begin
            r_sel <= w_gnt;
         end
         if (w_done) begin
            r_ptr <= r_sel + 2'd1;
         end
      end
   end

   // Valid is a decode of registered state, so an async reset clears it at once.
   assign out_valid = (r_state == S_SEND) ? (4'b0001 << r_sel) : 4'b0000;
   assign in_ready  = (r_state == S_IDLE);
   assign busy      = (r_state != S_IDLE);
   assign sel       = r_sel;
   assign out_data  = r_data;

endmodule

// File: tb/tb_demux_rr_dispatch.sv
// Bench for demux_rr_dispatch: item-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_demux_rr_dispatch;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic [3:0] mask;
   logic [3:0] out_ready;
   logic [1:0] sel;
   logic [3:0] out_valid;
   logic [7:0] out_data;
   logic       busy;

   demux_rr_dispatch #(.W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .mask      (mask),
      .out_ready (out_ready),
      .sel       (sel),
      .out_valid (out_valid),
      .out_data  (out_data),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_total = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: an item is either absent, held awaiting a grant, or
   // granted to consumer m_idx. The pointer names the highest-priority consumer.
   bit         m_hold;
   bit         m_gnt;
   int         m_idx;
   int         m_ptr;
   logic [7:0] m_data;

   function automatic int pick(input int p, input logic [3:0] cand);
      for (int d = 0; d < 4; d++) begin
         if (cand[(p + d) % 4]) return (p + d) % 4;
      end
      return -1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_hold <= 1'b0;
         m_gnt  <= 1'b0;
         m_idx  <= 0;
         m_ptr  <= 0;
         m_data <= 8'h00;
      end else if (!m_hold && !m_gnt) begin
         if (in_valid) begin
            m_hold <= 1'b1;
            m_data <= in_data;
         end
      end else if (m_hold) begin
         if (pick(m_ptr, mask & out_ready) >= 0) begin
            m_hold <= 1'b0;
            m_gnt  <= 1'b1;
            m_idx  <= pick(m_ptr, mask & out_ready);
         end
      end else if (out_ready[m_idx]) begin
         m_gnt <= 1'b0;
         m_ptr <= (m_idx + 1) % 4;
      end
   end

   // Completed transfers as seen on the DUT pins.
   int         cyc = 0;
   int         g_sel[$];
   logic [7:0] g_data[$];
   int         g_cyc[$];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst_n && ((out_valid & out_ready) != 4'b0000)) begin
         g_sel.push_back(int'(sel));
         g_data.push_back(out_data);
         g_cyc.push_back(cyc);
      end
   end

   int nv = 0;

   always @(negedge clk) begin
      chk("in_ready", 32'(in_ready), 32'(!m_hold && !m_gnt));
      chk("busy", 32'(busy), 32'(m_hold || m_gnt));
      chk("out_valid", 32'(out_valid), m_gnt ? 32'(4'b0001 << m_idx) : 32'd0);
      chk("sel", 32'(sel), 32'(m_idx));
      chk("out_data", 32'(out_data), 32'(m_data));
      if (out_valid != 4'b0000) nv <= nv + 1;
   end

   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic push(input logic [7:0] d);
      int t;
      t = 0;
      while (!in_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) chk("push_timeout", 32'd1, 32'd0);
      in_valid = 1'b1;
      in_data  = d;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_done(input int n);
      int t;
      t = 0;
      while (g_sel.size() < n && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (g_sel.size() < n) chk("done_timeout", 32'(g_sel.size()), 32'(n));
   endtask

   initial begin
      int base;
      int n0;
      logic [7:0] rr_items [6];
      int rr_sel [6];
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      mask      = 4'h0;
      out_ready = 4'h0;
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_sel", 32'(sel), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Round robin over all four consumers.
      rr_items = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
      rr_sel   = '{0, 1, 2, 3, 0, 1};
      mask = 4'hF;
      out_ready = 4'hF;
      base = g_sel.size();
      n0 = nv;
      for (int i = 0; i < 6; i++) push(rr_items[i]);
      wait_done(base + 6);
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         chk("rr_sel", 32'(g_sel[base + i]), 32'(rr_sel[i]));
         chk("rr_data", 32'(g_data[base + i]), 32'(rr_items[i]));
         if (i > 0) chk("rr_spacing", 32'(g_cyc[base + i] - g_cyc[base + i - 1]), 32'd3);
      end
      chk("rr_valid_cycles", 32'(nv - n0), 32'd6);

      // Masked consumers are skipped, with wrap.
      do_reset();
      mask = 4'b1010;
      out_ready = 4'hF;
      base = g_sel.size();
      push(8'h11);
      push(8'h22);
      push(8'h33);
      wait_done(base + 3);
      chk("skip_sel0", 32'(g_sel[base]), 32'd1);
      chk("skip_sel1", 32'(g_sel[base + 1]), 32'd3);
      chk("skip_sel2", 32'(g_sel[base + 2]), 32'd1);
      chk("skip_data2", 32'(g_data[base + 2]), 32'h33);
      @(negedge clk);

      // No candidate: stay in arbitration, holding the item.
      out_ready = 4'h0;
      mask = 4'hF;
      push(8'h5A);
      for (int i = 0; i < 10; i++) begin
         chk("stall_in_ready", 32'(in_ready), 32'd0);
         chk("stall_busy", 32'(busy), 32'd1);
         chk("stall_out_valid", 32'(out_valid), 32'd0);
         chk("stall_data", 32'(out_data), 32'h5A);
         @(negedge clk);
      end
      out_ready = 4'b0100;
      @(negedge clk);
      chk("stall_sel", 32'(sel), 32'd2);
      chk("stall_grant", 32'(out_valid), 32'b0100);
      @(negedge clk);

      // Backpressure on a granted transfer.
      mask = 4'b1000;
      out_ready = 4'b1000;
      push(8'hB3);
      @(negedge clk);
      out_ready = 4'b0000;
      chk("bp_valid0", 32'(out_valid), 32'b1000);
      @(negedge clk);
      chk("bp_valid1", 32'(out_valid), 32'b1000);
      @(negedge clk);
      out_ready = 4'b1000;
      chk("bp_valid2", 32'(out_valid), 32'b1000);
      @(negedge clk);
      chk("bp_done_valid", 32'(out_valid), 32'd0);
      chk("bp_done_ready", 32'(in_ready), 32'd1);
      mask = 4'hF;
      out_ready = 4'hF;
      base = g_sel.size();
      push(8'hB4);
      wait_done(base + 1);
      chk("bp_next_ptr", 32'(g_sel[base]), 32'd0);
      @(negedge clk);

      // Mask changes during a transfer are ignored.
      mask = 4'b0010;
      out_ready = 4'b0010;
      base = g_sel.size();
      push(8'hC1);
      @(negedge clk);
      mask = 4'b0001;
      out_ready = 4'b0000;
      @(negedge clk);
      chk("mc_hold", 32'(out_valid), 32'b0010);
      out_ready = 4'hF;
      wait_done(base + 1);
      chk("mc_sel", 32'(g_sel[base]), 32'd1);
      push(8'hC2);
      wait_done(base + 2);
      chk("mc_next", 32'(g_sel[base + 1]), 32'd0);
      @(negedge clk);

      // Asynchronous reset in the middle of a transfer.
      mask = 4'b0100;
      out_ready = 4'b0100;
      push(8'hD4);
      @(negedge clk);
      out_ready = 4'b0000;
      chk("ar_pre_valid", 32'(out_valid), 32'b0100);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_valid", 32'(out_valid), 32'd0);
      chk("ar_sel", 32'(sel), 32'd0);
      chk("ar_data", 32'(out_data), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("ar_in_ready", 32'(in_ready), 32'd1);
      chk("ar_busy", 32'(busy), 32'd0);
      @(negedge clk);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_data   = 8'($urandom);
         mask      = 4'($urandom);
         out_ready = 4'($urandom);
         if ($urandom_range(0, 199) == 0) begin
            #2 rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
         end else begin
            @(negedge clk);
         end
      end

      $display("%0d/%0d checks passed", n_total - n_fail, n_total);
      $finish;
   end

endmodule
